// File: rtl/instr_loader.sv
// Boot-time instruction memory writer: receives a counted, XOR-protected byte
// image over valid/ready and keeps the core stopped until it checks out.
module instr_loader #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9,
   parameter int BASE    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [INSTR_W-1:0] im_wdata,
   output logic              core_run,
   output logic              load_done,
   output logic              error,
   output logic [ADDR_W:0]   loaded_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     r_index;
   logic [ADDR_W:0]     r_loaded;
   logic [7:0]          r_lo;
   logic [7:0]          r_acc;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [INSTR_W-1:0]  r_wdata;
   logic                r_done;
   logic                r_err;
   logic                r_run;

   logic                w_rxState;
   logic                w_accept;
   logic                w_fmtBad;
   logic                w_last;
   logic [ADDR_W:0]     w_indexInc;
   logic [ADDR_W-1:0]   w_addr;

   assign w_rxState  = (r_state == S_IDLE) || (r_state == S_LO) ||
                       (r_state == S_HI)   || (r_state == S_CHK);
   assign in_ready   = reset && w_rxState && !restart;
   assign w_accept   = in_valid && in_ready;
   assign w_fmtBad   = |in_data[7:1];
   assign w_indexInc = r_index + 1'b1;
   assign w_last     = (w_indexInc == r_count);
   assign w_addr     = ADDR_W'(BASE) + r_index[ADDR_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (restart) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) w_next = S_LO;
            S_LO:   if (w_accept) w_next = S_HI;
            S_HI: begin
               if (w_accept) begin
                  if (w_fmtBad)    w_next = S_ERR;
                  else if (w_last) w_next = S_CHK;
                  else             w_next = S_LO;
               end
            end
            S_CHK: begin
               if (w_accept) w_next = (in_data == r_acc) ? S_DONE : S_ERR;
            end
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Status flags follow the next state so they rise together with DONE/ERR
   // and drop on restart without an extra cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count  <= '0;
         r_index  <= '0;
         r_loaded <= '0;
         r_lo     <= '0;
         r_acc    <= '0;
         r_we     <= 1'b0;
         r_addr   <= ADDR_W'(BASE);
         r_wdata  <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_run    <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= (w_next == S_DONE);
         r_run  <= (w_next == S_DONE);
         r_err  <= (w_next == S_ERR);
         if (restart) begin
            r_loaded <= '0;
            r_acc    <= '0;
         end else if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  r_count  <= (ADDR_W+1)'({(in_data == 8'd0), in_data});
                  r_acc    <= in_data;
                  r_index  <= '0;
                  r_loaded <= '0;
               end
               S_LO: begin
                  r_lo  <= in_data;
                  r_acc <= r_acc ^ in_data;
               end
               S_HI: begin
                  if (!w_fmtBad) begin
                     r_we     <= 1'b1;
                     r_addr   <= w_addr;
                     r_wdata  <= INSTR_W'({in_data[0], r_lo});
                     r_acc    <= r_acc ^ in_data;
                     r_index  <= w_indexInc;
                     r_loaded <= r_loaded + 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign im_we        = r_we;
   assign im_addr      = r_addr;
   assign im_wdata     = r_wdata;
   assign core_run     = r_run;
   assign load_done    = r_done;
   assign error        = r_err;
   assign loaded_count = r_loaded;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the 9-bit instruction memory. It is the write side that fills the store the controller fetches from.
- It accepts a byte stream over a valid/ready handshake: a header count byte, two bytes per instruction, and a trailing XOR checksum byte.
- It writes each 9-bit instruction to consecutive addresses and holds the core stopped until the image is loaded and verified.

Parameters:
ADDR_W, 8, instruction memory address width
INSTR_W, 9, instruction width (fixed at 9; the high byte carries bit 8)
BASE, 0, first instruction memory address written

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
restart  input  1  synchronous pulse; aborts or finishes the current session and returns to IDLE
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
im_we  output  1  instruction memory write strobe
im_addr  output  ADDR_W  instruction memory write address
im_wdata  output  INSTR_W  instruction memory write data
core_run  output  1  high releases the core; low holds it stopped
load_done  output  1  image loaded and checksum matched
error  output  1  format or checksum failure
loaded_count  output  ADDR_W+1  instructions written in the current session

Behaviour:
- Reset is asynchronous and active-low (reset=0). While it is low:
  - state=IDLE;
  - in_ready, im_we, core_run, load_done and error are all 0;
  - im_addr=BASE, im_wdata=0, loaded_count=0, checksum accumulator=0.
- Reset during a load abandons it. Words already written stay in memory, and core_run stays 0.
- A byte is accepted on a posedge where in_valid && in_ready.
- in_ready = (state in IDLE, LO, HI, CHK) && !restart. A byte presented in the same cycle as restart is not accepted.
- Checksum accumulator = XOR of every accepted byte, header included, excluding the checksum byte itself.
- State machine:
  - IDLE: on accept, latch count = in_data, with 0 meaning 256. Set accumulator = in_data and index = 0. Go to LO.
  - LO: on accept, latch lo = in_data and XOR it into the accumulator. Go to HI.
  - HI: on accept:
    - if in_data[7:1] != 0, go to ERR with no write;
    - else register the write: on the next cycle im_we=1 for exactly one cycle, im_addr = (BASE+index) mod 2^ADDR_W, im_wdata = {in_data[0], lo];
    - XOR in_data into the accumulator, index++, loaded_count++;
    - if index == count after the increment go to CHK, else go to LO.
  - CHK: on accept, go to DONE if in_data == accumulator, else go to ERR.
  - DONE: load_done=1 and core_run=1, both registered and asserted the cycle after the checksum byte is accepted. in_ready=0.
  - ERR: error=1 and core_run=0. in_ready=0.
- restart (synchronous, any state): next state is IDLE. Clears load_done, error, core_run, loaded_count and the accumulator. An im_we already registered from the previous cycle still completes.
- Address wrap: BASE + index wraps modulo 2^ADDR_W. A count of 256 with BASE=0 writes addresses 0..255.
- im_addr and im_wdata hold their last values while im_we=0.
- Back-to-back valid bytes are accepted every cycle, so there are no bubbles. Sustained throughput is one instruction per 2 cycles.
- in_valid low in any receiving state means the FSM waits indefinitely. There is no timeout.

Test Plan:
1. Basic load. Stream 0x02, 0x34, 0x01, 0xAB, 0x00, 0x9C with valid held high.
   - Required writes: im_we pulses with addr 0 data 9'h134, then addr 1 data 9'h0AB.
   - load_done=1 and core_run=1 the cycle after 0x9C is accepted; loaded_count=2; in_ready then 0.
2. Bad checksum. Same stream ending 0x9D.
   - Required: two writes occur, error=1, core_run=0, load_done=0, in_ready=0.
3. Format error. Stream 0x01, 0x55, 0x02.
   - Required: ERR with no im_we pulse, error=1, loaded_count=0.
4. Backpressure and gaps. Test 1 stream with in_valid toggling randomly, and restart pulsed while in_valid is high in IDLE.
   - Required: same writes and result as test 1.
   - The byte coincident with restart is not consumed.
5. Wrap and count=0. Use BASE=250 and header 0x00, i.e. 256 instructions, with data = index.
   - Required: writes to addresses 250..255 then 0..249; loaded_count=256.
   - DONE with the correct XOR checksum.
6. Reset and restart mid-load. Drive reset low after the first HI byte, release it, then run test 1.
   - Required: all outputs at reset values during reset, then normal completion.
   - Separately, restart in DONE returns to IDLE with core_run=0 and in_ready=1.
